// File: rtl/dmem_req_ctrl.sv
// Data-memory initiator: turns an EX/MEM load/store into a req/gnt/rvalid
// transaction, stalls the pipeline meanwhile and emits the MEM/WB bundle.
module dmem_req_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [1:0]  ex_wb_ctrl,
  input  logic [4:0]  ex_wb_addr,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic [31:0] out_result,
  output logic [1:0]  out_wb_ctrl,
  output logic [4:0]  out_wb_addr,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [1:0]  wb_ctrl_q;
  logic [4:0]  wb_addr_q;
  logic [7:0]  cnt_q;

  logic is_mem, misaligned, start, wr_done, rd_done, timeout, complete;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    is_mem     = ex_memread | ex_memwrite;
    misaligned = ex_addr[1:0] != 2'b00;
    start      = (state_q == IDLE) && ex_valid && is_mem && !misaligned;
    wr_done    = (state_q == REQ) && we_q && mem_gnt;
    rd_done    = (state_q == WAIT_R) && mem_rvalid;
    // A real completion on the limit cycle takes precedence over the abort.
    timeout    = (state_q != IDLE) && !(wr_done || rd_done)
                 && (cnt_q == 8'(MAX_WAIT - 1));
    complete   = wr_done | rd_done | timeout;
    stall      = start | ((state_q != IDLE) & !complete);

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ: begin
        if (timeout)      state_d = IDLE;
        else if (mem_gnt) state_d = we_q ? IDLE : WAIT_R;
      end
      WAIT_R:  if (rd_done || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q[31:2];
  assign mem_wdata = wdata_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      wb_ctrl_q    <= '0;
      wb_addr_q    <= '0;
      cnt_q        <= '0;
      out_valid    <= 1'b0;
      out_rdata    <= '0;
      out_result   <= '0;
      out_wb_ctrl  <= '0;
      out_wb_addr  <= '0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;

      if (start) cnt_q <= '0;
      else if (state_q != IDLE) cnt_q <= cnt_q + 8'd1;

      if (state_q == IDLE && ex_valid) begin
        if (start) begin
          addr_q    <= ex_addr;
          wdata_q   <= ex_wdata;
          we_q      <= ex_memwrite;
          wb_ctrl_q <= ex_wb_ctrl;
          wb_addr_q <= ex_wb_addr;
        end else begin
          // Non-mem op, or a misaligned access that is suppressed in place.
          out_valid   <= 1'b1;
          out_rdata   <= '0;
          out_result  <= ex_addr;
          out_wb_ctrl <= is_mem ? {ex_wb_ctrl[1], 1'b0} : ex_wb_ctrl;
          out_wb_addr <= ex_wb_addr;
          if (is_mem) misalign_err <= 1'b1;
        end
      end

      if (complete) begin
        out_valid   <= 1'b1;
        out_rdata   <= rd_done ? mem_rdata : 32'd0;
        out_result  <= addr_q;
        out_wb_ctrl <= timeout ? {wb_ctrl_q[1], 1'b0} : wb_ctrl_q;
        out_wb_addr <= wb_addr_q;
        if (timeout) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl: stimulus pushes expected write-back
// bundles into a queue, a negedge monitor pops and compares on out_valid.
module tb_dmem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_memread, ex_memwrite;
  logic [31:0] ex_addr, ex_wdata;
  logic [1:0]  ex_wb_ctrl;
  logic [4:0]  ex_wb_addr;
  logic        stall, mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_rdata, out_result;
  logic [1:0]  out_wb_ctrl;
  logic [4:0]  out_wb_addr;
  logic        misalign_err, timeout_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] result;
    logic [1:0]  wb_ctrl;
    logic [4:0]  wb_addr;
  } bundle_t;

  bundle_t exp_q[$];
  int      n_checks = 0;
  int      n_pass   = 0;

  always #5 clk = ~clk;

  dmem_req_ctrl #(.MAX_WAIT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_wb_ctrl(ex_wb_ctrl),
    .ex_wb_addr(ex_wb_addr), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_rdata(out_rdata), .out_result(out_result),
    .out_wb_ctrl(out_wb_ctrl), .out_wb_addr(out_wb_addr),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Inputs change 2 time units after the rising edge; comb outputs are
  // checked 1 unit later and registered outputs at the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [1:0] wbc, input logic [4:0] wba);
    ex_valid    = 1'b1;
    ex_memread  = rd;
    ex_memwrite = wr;
    ex_addr     = addr;
    ex_wdata    = wdata;
    ex_wb_ctrl  = wbc;
    ex_wb_addr  = wba;
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        bundle_t e;
        e = exp_q.pop_front();
        check("out_rdata",   out_rdata,           e.rdata);
        check("out_result",  out_result,          e.result);
        check("out_wb_ctrl", {30'd0, out_wb_ctrl}, {30'd0, e.wb_ctrl});
        check("out_wb_addr", {27'd0, out_wb_addr}, {27'd0, e.wb_addr});
      end
    end
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_addr = '0; ex_wdata = '0; ex_wb_ctrl = '0; ex_wb_addr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst_mem_req",   {31'd0, mem_req},   32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mem_addr",  {2'd0, mem_addr},   32'd0);
    check("rst_errors",    {30'd0, misalign_err, timeout_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Non-mem op: passes straight through in one cycle.
    op(1'b0, 1'b0, 32'h40, 32'h0, 2'b01, 5'd5);
    exp_q.push_back('{32'h0, 32'h40, 2'b01, 5'd5});
    #1 check("nonmem_stall", {31'd0, stall}, 32'd0);
    check("nonmem_req", {31'd0, mem_req}, 32'd0);
    tick(); ex_valid = 1'b0;
    check("nonmem_latency", {31'd0, out_valid}, 32'd1);

    // Load 0x10: grant on the 3rd REQ cycle, rvalid 3 cycles after grant.
    tick();
    op(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd7);
    exp_q.push_back('{32'hDEADBEEF, 32'h10, 2'b11, 5'd7});
    #1 check("ld_stall_c0", {31'd0, stall}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) mem_gnt = 1'b1;
      #1 check("ld_req", {31'd0, mem_req}, 32'd1);
      check("ld_addr", {2'd0, mem_addr}, 32'h4);
      check("ld_we", {31'd0, mem_we}, 32'd0);
      check("ld_stall_req", {31'd0, stall}, 32'd1);
    end
    for (int c = 4; c <= 6; c++) begin
      tick();
      mem_gnt = 1'b0;
      if (c == 6) begin mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; end
      #1 check("ld_wait_req", {31'd0, mem_req}, 32'd0);
      check("ld_wait_stall", {31'd0, stall}, (c == 6) ? 32'd0 : 32'd1);
    end
    tick();
    mem_rvalid = 1'b0;
    check("ld_latency", {31'd0, out_valid}, 32'd1);
    op(1'b0, 1'b0, 32'h200, 32'h0, 2'b01, 5'd3);
    exp_q.push_back('{32'h0, 32'h200, 2'b01, 5'd3});
    tick(); ex_valid = 1'b0;
    check("next_op_valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("next_op_once", {31'd0, out_valid}, 32'd0);

    // Store 0x8 with immediate grant; a stray rvalid afterwards is ignored.
    op(1'b0, 1'b1, 32'h8, 32'h1234, 2'b00, 5'd0);
    exp_q.push_back('{32'h0, 32'h8, 2'b00, 5'd0});
    #1 check("st_stall_c0", {31'd0, stall}, 32'd1);
    tick();
    ex_valid = 1'b0; mem_gnt = 1'b1;
    #1 check("st_req", {31'd0, mem_req}, 32'd1);
    check("st_we", {31'd0, mem_we}, 32'd1);
    check("st_addr", {2'd0, mem_addr}, 32'h2);
    check("st_wdata", mem_wdata, 32'h1234);
    check("st_stall_gnt", {31'd0, stall}, 32'd0);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    check("st_latency", {31'd0, out_valid}, 32'd1);
    check("st_req_drop", {31'd0, mem_req}, 32'd0);
    tick();
    mem_rvalid = 1'b0;
    check("late_rvalid_ignored", {31'd0, out_valid}, 32'd0);
    check("late_rvalid_rdata", out_rdata, 32'h0);

    // Misaligned load: no request, sticky error, regwrite suppressed.
    op(1'b1, 1'b0, 32'h6, 32'h0, 2'b11, 5'd4);
    exp_q.push_back('{32'h0, 32'h6, 2'b10, 5'd4});
    #1 check("mis_stall", {31'd0, stall}, 32'd0);
    check("mis_req", {31'd0, mem_req}, 32'd0);
    tick(); ex_valid = 1'b0;
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_valid", {31'd0, out_valid}, 32'd1);

    // Load whose grant never comes: aborts on the 16th busy cycle.
    tick();
    op(1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 5'd8);
    exp_q.push_back('{32'h0, 32'h20, 2'b10, 5'd8});
    for (int c = 1; c <= 16; c++) begin
      tick();
      #1 check("to_stall", {31'd0, stall}, (c == 16) ? 32'd0 : 32'd1);
    end
    tick(); ex_valid = 1'b0;
    check("to_valid", {31'd0, out_valid}, 32'd1);
    check("to_err", {31'd0, timeout_err}, 32'd1);
    check("to_req", {31'd0, mem_req}, 32'd0);
    check("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // Reset while waiting for read data; the late rvalid must be dropped.
    tick();
    op(1'b1, 1'b0, 32'h30, 32'h0, 2'b11, 5'd2);
    tick(); mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; ex_valid = 1'b0; rst_n = 1'b0;
    tick(); rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
    #1 check("rst_wr_req", {31'd0, mem_req}, 32'd0);
    check("rst_wr_stall", {31'd0, stall}, 32'd0);
    check("rst_wr_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
    tick(); mem_rvalid = 1'b0;
    check("rst_wr_no_valid", {31'd0, out_valid}, 32'd0);
    op(1'b1, 1'b0, 32'h44, 32'h0, 2'b11, 5'd6);
    exp_q.push_back('{32'h0BADF00D, 32'h44, 2'b11, 5'd6});
    tick(); ex_valid = 1'b0; mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
    tick(); mem_rvalid = 1'b0;
    check("post_rst_ld_valid", {31'd0, out_valid}, 32'd1);

    tick(); tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_req_ctrl.md
Name: dmem_req_ctrl

Overview:
- Initiator side of the data-memory interface: takes a load/store from the EX/MEM boundary and issues a request/grant/response transaction to a variable-latency data memory.
- Stalls the pipeline while the transaction is outstanding.
- Delivers the write-back bundle (read data, ALU result, WB control, destination register) to the MEM/WB stage.
- Replaces the zero-latency combinational memory access with a handshaked one.

Parameters:
- MAX_WAIT, 16, cycles spent in REQ+WAIT_R before a transaction is aborted (range 2..255).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- ex_valid  in  1  EX presents an instruction this cycle.
- ex_memread  in  1  load.
- ex_memwrite  in  1  store; has priority if both are set.
- ex_addr  in  32  byte address / ALU result.
- ex_wdata  in  32  store data.
- ex_wb_ctrl  in  2  [0]=regwrite, [1]=memtoreg.
- ex_wb_addr  in  5  destination register.
- stall  out  1  hold upstream stages.
- mem_req  out  1  request valid.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  30  word address = addr[31:2].
- mem_wdata  out  32  write data.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- out_valid  out  1  one-cycle pulse; write-back bundle valid.
- out_rdata  out  32  load data (0 for non-loads).
- out_result  out  32  latched ex_addr.
- out_wb_ctrl  out  2  latched WB control; regwrite forced 0 on error.
- out_wb_addr  out  5  latched destination register.
- misalign_err  out  1  sticky.
- timeout_err  out  1  sticky.

Behaviour:
- Reset (synchronous, any state):
  - State goes to IDLE.
  - All outputs, latches, wait counter and sticky errors are 0.
  - An in-flight transaction is dropped. A late mem_gnt or mem_rvalid seen in IDLE is ignored.
- States: IDLE, REQ, WAIT_R.
- IDLE, ex_valid=1, no mem op:
  - Bundle is registered; out_valid pulses next cycle with out_rdata=0.
  - stall=0.
- IDLE, ex_valid=1, mem op with ex_addr[1:0]!=0:
  - No request is issued.
  - misalign_err is set.
  - Bundle is registered with regwrite=0 and rdata=0; out_valid pulses next cycle.
  - stall=0.
- IDLE, ex_valid=1, aligned mem op:
  - Addr, wdata, we, wb_ctrl and wb_addr are latched; state goes to REQ.
  - stall=1 combinationally in this cycle.
- REQ:
  - mem_req=1; mem_we, mem_addr and mem_wdata are held stable until mem_gnt.
  - mem_rvalid is ignored.
  - On mem_gnt for a write: go to IDLE; out_valid next cycle.
  - On mem_gnt for a read: go to WAIT_R. mem_req drops the cycle after grant.
- WAIT_R:
  - mem_req=0.
  - On mem_rvalid: mem_rdata is captured into out_rdata; go to IDLE; out_valid next cycle.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT_R.
  - When it reaches MAX_WAIT with no completion: abort to IDLE and set timeout_err.
  - Bundle is emitted with regwrite=0 and rdata=0.
  - Completion in the same cycle as the limit wins over timeout.
- stall:
  - stall = start_cond | (state!=IDLE & !complete).
  - complete = write gnt | read rvalid | timeout.
  - stall is low in the completion cycle so upstream advances on that edge.
  - ex_* inputs are ignored while state!=IDLE.
- Latency:
  - Non-mem op: out_valid at cycle 1.
  - Write with gnt at cycle 1: out_valid at cycle 2.
  - Read with gnt at cycle 1 and rvalid at cycle 2: out_valid at cycle 3.
- out_* hold their last values between pulses; only out_valid returns to 0.
- Word address is addr[31:2]; no sign or zero extension is applied.

Test Plan:
- Non-mem op (ex_addr=0x40, wb_ctrl=01, wb_addr=5) -> stall=0, no mem_req; cycle 1: out_valid=1, result=0x40, rdata=0, wb_addr=5.
- Load addr=0x10, gnt after 2 REQ cycles, rvalid 3 cycles later with rdata=0xDEADBEEF -> mem_addr=0x4, mem_we=0 stable while waiting; stall high until the rvalid cycle; out_rdata=0xDEADBEEF with one out_valid pulse; next op is accepted exactly once.
- Store addr=0x8, wdata=0x1234, immediate gnt -> mem_we=1, mem_addr=0x2 for 1 cycle; out_valid at cycle 2; a late rvalid is ignored.
- Load addr=0x6 -> no mem_req, misalign_err=1 (sticky), out_wb_ctrl[0]=0; cleared only by rst_n.
- Load, gnt never arrives (MAX_WAIT=16) -> abort after 16 cycles: timeout_err=1, out_valid with regwrite=0, stall released.
- rst_n=0 in WAIT_R, then rvalid next cycle -> IDLE, mem_req=0, no out_valid; the next aligned load completes normally.
